// File: rtl/sobel_window.sv
// sobel_window: raster 8-bit pixel stream to 3x3 neighbourhoods (two line buffers + window) with centre coordinates.
// Ports: clk, rst (sync, active-high); pix_in/pix_valid/sof in; a0..a7, center, win_valid, cx, cy, frame_done out.
module sobel_window #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int XW     = 10,
  parameter int YW     = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    pix_in,
  input  logic          pix_valid,
  input  logic          sof,
  output logic [7:0]    a0,
  output logic [7:0]    a1,
  output logic [7:0]    a2,
  output logic [7:0]    a3,
  output logic [7:0]    a4,
  output logic [7:0]    a5,
  output logic [7:0]    a6,
  output logic [7:0]    a7,
  output logic [7:0]    center,
  output logic          win_valid,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic          frame_done
);
  localparam int AW = $clog2(WIDTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;
  logic [XW-1:0] x, px;
  logic [YW-1:0] y, py;
  logic [7:0] lb0 [WIDTH];
  logic [7:0] lb1 [WIDTH];
  logic [7:0] t0, t1, m0, m1, b0, b1, r0, r1;
  logic acc, emit, last_x, last_y;
  always_comb begin
    acc    = pix_valid && (sof || state == ACTIVE);
    px     = sof ? '0 : x;
    py     = sof ? '0 : y;
    r0     = lb0[px[AW-1:0]];
    r1     = lb1[px[AW-1:0]];
    last_x = px == XW'(WIDTH - 1);
    last_y = py == YW'(HEIGHT - 1);
    emit   = acc && px >= XW'(2) && py >= YW'(2);
  end
  // Storage and horizontal shift registers are unreset: every row refills the shift pair before the first window.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1[px[AW-1:0]] <= pix_in;
      lb0[px[AW-1:0]] <= r1;
      t1 <= t0;
      t0 <= r0;
      m1 <= m0;
      m0 <= r1;
      b1 <= b0;
      b0 <= pix_in;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      {a0, a1, a2, a3, a4, a5, a6, a7, center} <= '0;
      cx         <= '0;
      cy         <= '0;
    end else begin
      win_valid  <= emit;
      frame_done <= acc && last_x && last_y;
      if (acc) begin
        state <= (last_x && last_y) ? IDLE : ACTIVE;
        x     <= last_x ? '0 : px + 1'b1;
        y     <= last_x ? (last_y ? '0 : py + 1'b1) : py;
      end
      if (emit) begin
        a0     <= t1;
        a1     <= t0;
        a2     <= r0;
        a7     <= m1;
        center <= m0;
        a3     <= r1;
        a6     <= b1;
        a5     <= b0;
        a4     <= pix_in;
        cx     <= px - 1'b1;
        cy     <= py - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sobel_window.sv
// tb_sobel_window: randomized and directed checks of sobel_window against an image-array reference model.
module tb_sobel_window;
  logic clk = 0, rst = 1, pix_valid = 0, sof = 0;
  logic [7:0] pix_in = 0;
  always #5 clk = ~clk;

  logic [7:0] s_a0, s_a1, s_a2, s_a3, s_a4, s_a5, s_a6, s_a7, s_c;
  logic s_wv, s_fd;
  logic [9:0] s_cx, s_cy;
  logic [7:0] b_a0, b_a1, b_a2, b_a3, b_a4, b_a5, b_a6, b_a7, b_c;
  logic b_wv, b_fd;
  logic [4:0] b_cx;
  logic [3:0] b_cy;
  wire [71:0] s_win = {s_a0, s_a1, s_a2, s_a7, s_c, s_a3, s_a6, s_a5, s_a4};
  wire [71:0] b_win = {b_a0, b_a1, b_a2, b_a7, b_c, b_a3, b_a6, b_a5, b_a4};

  sobel_window #(.WIDTH(4), .HEIGHT(4), .XW(10), .YW(10)) dut_s (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .a0(s_a0), .a1(s_a1), .a2(s_a2), .a3(s_a3), .a4(s_a4), .a5(s_a5), .a6(s_a6), .a7(s_a7),
    .center(s_c), .win_valid(s_wv), .cx(s_cx), .cy(s_cy), .frame_done(s_fd));

  sobel_window #(.WIDTH(24), .HEIGHT(12), .XW(5), .YW(4)) dut_b (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .a0(b_a0), .a1(b_a1), .a2(b_a2), .a3(b_a3), .a4(b_a4), .a5(b_a5), .a6(b_a6), .a7(b_a7),
    .center(b_c), .win_valid(b_wv), .cx(b_cx), .cy(b_cy), .frame_done(b_fd));

  int n_chk = 0, n_fail = 0;
  logic [7:0] img [0:15][0:31];
  bit m_act;
  int mx, my;
  bit ewv, efd;
  logic [71:0] ewin;
  int ecx, ecy;

  // Drive one cycle and advance the reference model: the frame is stored as a 2-D image and the
  // expected window is simply the 3x3 block ending at the accepted pixel.
  task automatic send(input bit v, input bit s, input logic [7:0] p, input int w, input int h);
    pix_valid = v; sof = s; pix_in = p;
    @(posedge clk);
    ewv = 0; efd = 0;
    if (v && (s || m_act)) begin
      if (s) begin mx = 0; my = 0; m_act = 1; end
      img[my][mx] = p;
      if (mx >= 2 && my >= 2) begin
        ewv = 1;
        ewin = {img[my-2][mx-2], img[my-2][mx-1], img[my-2][mx],
                img[my-1][mx-2], img[my-1][mx-1], img[my-1][mx],
                img[my][mx-2],   img[my][mx-1],   img[my][mx]};
        ecx = mx - 1; ecy = my - 1;
      end
      if (mx == w - 1) begin
        mx = 0;
        if (my == h - 1) begin my = 0; m_act = 0; efd = 1; end
        else my++;
      end else mx++;
    end
    #1;
    pix_valid = 0; sof = 0;
  endtask

  task automatic do_reset();
    rst = 1; pix_valid = 0; sof = 0;
    @(posedge clk); #1;
    rst = 0; m_act = 0; mx = 0; my = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (s_win !== 72'd0 || s_wv !== 1'b0 || s_fd !== 1'b0 || s_cx !== 10'd0 || s_cy !== 10'd0) begin
      n_fail++;
      $display("FAIL reset: win=%h wv=%b fd=%b cx=%0d cy=%0d, want all zero", s_win, s_wv, s_fd, s_cx, s_cy);
    end
  endtask

  task automatic test_basic();
    int nw = 0, nfd = 0;
    for (int i = 0; i < 16; i++) begin
      send(1, i == 0, 8'(i), 4, 4);
      n_chk++;
      if (s_wv !== ewv || s_fd !== efd) begin
        n_fail++;
        $display("FAIL basic strobes px%0d: wv=%b fd=%b want %b %b", i, s_wv, s_fd, ewv, efd);
      end
      if (ewv) begin
        n_chk++;
        if (s_win !== ewin || s_cx !== ecx[9:0] || s_cy !== ecy[9:0]) begin
          n_fail++;
          $display("FAIL basic window px%0d: %h (%0d,%0d) want %h (%0d,%0d)", i, s_win, s_cx, s_cy, ewin, ecx, ecy);
        end
        if (nw == 0) begin
          n_chk++;
          if (s_win !== 72'h000102_040506_08090a || s_cx !== 10'd1 || s_cy !== 10'd1) begin
            n_fail++;
            $display("FAIL basic first window: %h (%0d,%0d) want 00010204050608090a (1,1)", s_win, s_cx, s_cy);
          end
        end
        nw++;
      end
      if (s_fd) nfd++;
    end
    send(0, 0, 8'h00, 4, 4);
    n_chk++;
    if (s_wv !== 1'b0 || s_fd !== 1'b0 || nw != 4 || nfd != 1) begin
      n_fail++;
      $display("FAIL basic count: windows=%0d fd_pulses=%0d tail wv=%b fd=%b want 4 1 0 0", nw, nfd, s_wv, s_fd);
    end
  endtask

  task automatic test_gaps();
    int nw = 0;
    bit seen = 0;
    logic [71:0] lw = '0;
    int lx = 0, ly = 0;
    for (int i = 0; i < 16; i++) begin
      send(0, 0, 8'($urandom), 4, 4);
      n_chk++;
      if (s_wv !== 1'b0 || s_fd !== 1'b0 || (seen && (s_win !== lw || s_cx !== lx[9:0] || s_cy !== ly[9:0]))) begin
        n_fail++;
        $display("FAIL gaps hold px%0d: wv=%b fd=%b win=%h want wv 0 fd 0 win %h", i, s_wv, s_fd, s_win, lw);
      end
      send(1, i == 0, 8'(i), 4, 4);
      n_chk++;
      if (s_wv !== ewv || s_fd !== efd || (ewv && (s_win !== ewin || s_cx !== ecx[9:0] || s_cy !== ecy[9:0]))) begin
        n_fail++;
        $display("FAIL gaps window px%0d: wv=%b fd=%b win=%h want %b %b %h", i, s_wv, s_fd, s_win, ewv, efd, ewin);
      end
      if (ewv) begin nw++; seen = 1; lw = ewin; lx = ecx; ly = ecy; end
    end
    n_chk++;
    if (nw != 4) begin n_fail++; $display("FAIL gaps count: windows=%0d want 4", nw); end
  endtask

  task automatic test_no_sof();
    int nw = 0, bad = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send(1, 0, 8'($urandom), 4, 4);
      if (s_wv !== 1'b0 || s_fd !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL no_sof drop: %0d strobes seen want 0", bad); end
    for (int i = 0; i < 16; i++) begin
      send(1, i == 0, 8'(200 + i), 4, 4);
      n_chk++;
      if (s_wv !== ewv || s_fd !== efd || (ewv && s_win !== ewin)) begin
        n_fail++;
        $display("FAIL no_sof frame px%0d: wv=%b win=%h want %b %h", i, s_wv, s_win, ewv, ewin);
      end
      if (s_wv) nw++;
    end
    n_chk++;
    if (nw != 4) begin n_fail++; $display("FAIL no_sof count: windows=%0d want 4", nw); end
  endtask

  task automatic test_abort();
    int nfd = 0;
    bit first = 1;
    for (int i = 0; i < 7; i++) begin
      send(1, i == 0, 8'(50 + i), 4, 4);
      if (s_fd) nfd++;
    end
    for (int i = 0; i < 16; i++) begin
      send(1, i == 0, 8'(100 + i), 4, 4);
      n_chk++;
      if (s_wv !== ewv || s_fd !== efd || (ewv && s_win !== ewin)) begin
        n_fail++;
        $display("FAIL abort px%0d: wv=%b fd=%b win=%h want %b %b %h", i, s_wv, s_fd, s_win, ewv, efd, ewin);
      end
      if (s_wv && first) begin
        first = 0;
        n_chk++;
        if (s_c !== 8'd105 || s_a0 !== 8'd100) begin
          n_fail++;
          $display("FAIL abort first window: center=%0d a0=%0d want 105 100", s_c, s_a0);
        end
      end
      if (s_fd) nfd++;
    end
    n_chk++;
    if (nfd != 1) begin n_fail++; $display("FAIL abort frame_done: pulses=%0d want 1", nfd); end
  endtask

  task automatic test_reset_mid();
    int nw = 0, bad = 0;
    for (int i = 0; i < 9; i++) send(1, i == 0, 8'(30 + i), 4, 4);
    rst = 1;
    send(1, 0, 8'd39, 4, 4);
    rst = 0; m_act = 0; mx = 0; my = 0;
    n_chk++;
    if (s_win !== 72'd0 || s_wv !== 1'b0 || s_fd !== 1'b0 || s_cx !== 10'd0 || s_cy !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_mid: win=%h wv=%b fd=%b cx=%0d cy=%0d want all zero", s_win, s_wv, s_fd, s_cx, s_cy);
    end
    for (int i = 0; i < 16; i++) begin
      send(1, 0, 8'(40 + i), 4, 4);
      if (s_wv !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL reset_mid drop: %0d windows want 0", bad); end
    for (int i = 0; i < 16; i++) begin
      send(1, i == 0, 8'(60 + i), 4, 4);
      if (s_wv) nw++;
      n_chk++;
      if (s_wv !== ewv || (ewv && s_win !== ewin)) begin
        n_fail++;
        $display("FAIL reset_mid frame px%0d: wv=%b win=%h want %b %h", i, s_wv, s_win, ewv, ewin);
      end
    end
    n_chk++;
    if (nw != 4) begin n_fail++; $display("FAIL reset_mid count: windows=%0d want 4", nw); end
  endtask

  task automatic test_random();
    int nw = 0, nfd = 0, steps = 0, errs = 0;
    bit started = 0;
    do_reset();
    while (steps < 2000 && !(started && !m_act)) begin
      bit v = ($urandom_range(0, 3) != 0);
      send(v, v && !started, 8'($urandom), 24, 12);
      if (v) started = 1;
      steps++;
      n_chk++;
      if (b_wv !== ewv || b_fd !== efd || (ewv && (b_win !== ewin || b_cx !== ecx[4:0] || b_cy !== ecy[3:0]))) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL random step%0d: wv=%b fd=%b win=%h (%0d,%0d) want %b %b %h (%0d,%0d)",
                   steps, b_wv, b_fd, b_win, b_cx, b_cy, ewv, efd, ewin, ecx, ecy);
      end
      if (b_wv) nw++;
      if (b_fd) nfd++;
    end
    n_chk++;
    if (nw != 220 || nfd != 1) begin
      n_fail++;
      $display("FAIL random count: windows=%0d fd_pulses=%0d want 220 1", nw, nfd);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_no_sof();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sobel_window.md
Name: sobel_window

Overview:
- Upstream neighbour of the Sobel gradient stage: converts a raster-order 8-bit grayscale pixel stream into 3x3 neighbourhoods.
- Two line buffers plus a 3x3 register window; emits the eight neighbours and the centre pixel with a valid strobe and centre coordinates.
- Sits between the camera/frame-buffer reader and the gradient operator; only interior centres (no border pixels) produce windows.

Parameters:
- WIDTH, 640, image width in pixels (>= 3)
- HEIGHT, 480, image height in lines (>= 3)
- XW, 10, coordinate width for x (2^XW >= WIDTH)
- YW, 10, coordinate width for y (2^YW >= HEIGHT)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pix_in  in  8  input pixel
- pix_valid  in  1  pix_in accepted on this rising edge when high
- sof  in  1  start of frame; qualifies pix_in as pixel (0,0) when high with pix_valid
- a0,a1,a2  out  8 each  top row of window (left, middle, right)
- a7,a3  out  8 each  middle row left, right
- a6,a5,a4  out  8 each  bottom row (left, middle, right)
- center  out  8  centre pixel
- win_valid  out  1  window outputs valid this cycle (single-cycle strobe per window)
- cx  out  XW  x coordinate of centre
- cy  out  YW  y coordinate of centre
- frame_done  out  1  one-cycle pulse after last pixel of frame accepted

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high; ports named clk and rst.
- Reset: all outputs 0; x/y counters 0; FSM to IDLE. Line-buffer contents need not be cleared (never exposed before rewritten).
- FSM states:
  - IDLE: pixels without sof dropped. pix_valid&sof -> accept as (0,0), go ACTIVE.
  - ACTIVE: each pix_valid accepts the pixel at the current (x,y); x increments, wraps to 0 at WIDTH-1 with y++.
  - ACTIVE, accept (WIDTH-1,HEIGHT-1): pulse frame_done next cycle, go IDLE.
  - ACTIVE, pix_valid&sof: abort current frame; this pixel becomes (0,0); no frame_done pulse; stay ACTIVE.
- Input gaps: pix_valid low holds counters, window and line buffers unchanged; win_valid low that cycle.
- Window mapping for accepted pixel at (x,y):
  - a0=(y-2,x-2), a1=(y-2,x-1), a2=(y-2,x)
  - a7=(y-1,x-2), center=(y-1,x-1), a3=(y-1,x)
  - a6=(y,x-2), a5=(y,x-1), a4=(y,x)
- Window emission: on the edge accepting pixel (x,y) with x>=2 and y>=2, register the window outputs and set cx=x-1, cy=y-1, win_valid=1 for the following cycle.
- Latency: one cycle from accepting the bottom-right pixel to win_valid.
- Window count: (WIDTH-2)*(HEIGHT-2) windows per full frame.
- Window state across rows: window columns must not mix rows. Horizontal shift state restarts at x=0; the first valid window of each row uses only that row's pixels.
- Line buffers: WIDTH entries each. Write at x on every accepted pixel: buffer1 <= pix_in, buffer0 <= old buffer1[x]. Read-before-write semantics at the same address.
- Output holding: window outputs, cx and cy hold their last values when win_valid is low.
- Counters: never exceed WIDTH-1 / HEIGHT-1.
- frame_done and win_valid may assert in the same cycle (last window of frame).
- Reset mid-frame: counters cleared; next window only after a new sof and two full lines.

Test Plan:
- WIDTH=4, HEIGHT=4, pixels 0..15 raster, continuous valid, sof on first -> exactly 4 windows, at (1,1),(2,1),(1,2),(2,2). First: a0=0,a1=1,a2=2,a7=4,center=5,a3=6,a6=8,a5=9,a4=10. frame_done one cycle after pixel 15 accepted, coincident with the last win_valid.
- Same frame with pix_valid toggling every other cycle -> identical window values and order; win_valid only the cycle after accepting edges.
- Pixels sent before any sof after reset -> ignored, no win_valid. Then a full frame with sof -> normal 4 windows.
- sof reasserted mid-frame at pixel 7 with new pixels 100..115 -> first window center=105, a0=100. No frame_done for the aborted frame.
- rst pulsed at pixel 9 of a frame -> all outputs 0 the next cycle. Subsequent pixels dropped until sof.
- Default 640x480 frame of random pixels vs software reference -> 638*478 windows matching reference neighbourhoods, cx/cy correct.
